// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: pulse generator FSM states and default field widths
// reused by the GPIO register map.
package gpio_pkg;

  typedef enum logic [1:0] {
    PG_IDLE = 2'd0,
    PG_HIGH = 2'd1,
    PG_LOW  = 2'd2
  } pulse_state_t;

  localparam int unsigned GPIO_CNT_W = 16;
  localparam int unsigned GPIO_REP_W = 8;

endpackage

// File: rtl/gpio_pulse_gen.sv
// GPIO pulse-train generator: accepts (high, low, count) over valid/ready and drives
// a registered pad with count active/idle pulses, then strobes done.
module gpio_pulse_gen
  import gpio_pkg::*;
#(
  parameter int unsigned CNT_W       = GPIO_CNT_W,
  parameter int unsigned REP_W       = GPIO_REP_W,
  parameter logic        ACTIVE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_high_cycles,
  input  logic [CNT_W-1:0] cmd_low_cycles,
  input  logic [REP_W-1:0] cmd_count,
  input  logic             abort,
  output logic             pin_out,
  output logic             busy,
  output logic             done,
  output logic             done_aborted
);

  localparam logic PinActive = ACTIVE_HIGH;
  localparam logic PinIdle   = ~ACTIVE_HIGH;

  pulse_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             pin_q, pin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_ab_q, done_ab_d;

  logic             accept;
  logic [CNT_W-1:0] high_m1, low_m1;

  assign cmd_ready = (state_q == PG_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // Reload values are (length - 1); a zero length behaves as one cycle.
  assign high_m1 = (cmd_high_cycles == '0) ? '0 : cmd_high_cycles - CNT_W'(1);
  assign low_m1  = (cmd_low_cycles == '0) ? '0 : cmd_low_cycles - CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    high_d    = high_q;
    low_d     = low_q;
    rep_d     = rep_q;
    pin_d     = pin_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_ab_d = 1'b0;
    case (state_q)
      PG_IDLE: begin
        if (accept) begin
          high_d = high_m1;
          low_d  = low_m1;
          if (cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = PG_HIGH;
            cnt_d   = high_m1;
            rep_d   = cmd_count - REP_W'(1);
            pin_d   = PinActive;
            busy_d  = 1'b1;
          end
        end
      end
      PG_HIGH: begin
        if (abort) begin
          state_d   = PG_IDLE;
          cnt_d     = '0;
          pin_d     = PinIdle;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          done_ab_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = PG_LOW;
          cnt_d   = low_q;
          pin_d   = PinIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PG_LOW: begin
        if (abort || (cnt_q == '0 && rep_q == '0)) begin
          state_d   = PG_IDLE;
          cnt_d     = '0;
          pin_d     = PinIdle;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          done_ab_d = abort;
        end else if (cnt_q == '0) begin
          state_d = PG_HIGH;
          cnt_d   = high_q;
          rep_d   = rep_q - REP_W'(1);
          pin_d   = PinActive;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = PG_IDLE;
        pin_d   = PinIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PG_IDLE;
      cnt_q     <= '0;
      high_q    <= '0;
      low_q     <= '0;
      rep_q     <= '0;
      pin_q     <= PinIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_ab_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      high_q    <= high_d;
      low_q     <= low_d;
      rep_q     <= rep_d;
      pin_q     <= pin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_ab_q <= done_ab_d;
    end
  end

  assign pin_out      = pin_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign done_aborted = done_ab_q;

endmodule

// File: tb/tb_gpio_pulse_gen.sv
// Bench for gpio_pulse_gen: an arithmetic train model checked every cycle against
// both polarities, plus directed scenarios with hand-computed waveforms.
module tb_gpio_pulse_gen;

  localparam int unsigned CW = 16;
  localparam int unsigned RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [CW-1:0] cmd_h, cmd_l;
  logic [RW-1:0] cmd_n;
  logic          abort;
  logic          ready, pin, busy, done, done_ab;
  logic          ready_n, pin_n, busy_n, done_n, done_ab_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpio_pulse_gen #(.CNT_W(CW), .REP_W(RW), .ACTIVE_HIGH(1'b1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready),
    .cmd_high_cycles(cmd_h), .cmd_low_cycles(cmd_l), .cmd_count(cmd_n),
    .abort(abort), .pin_out(pin), .busy(busy), .done(done), .done_aborted(done_ab)
  );

  gpio_pulse_gen #(.CNT_W(CW), .REP_W(RW), .ACTIVE_HIGH(1'b0)) u_dut_n (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_n),
    .cmd_high_cycles(cmd_h), .cmd_low_cycles(cmd_l), .cmd_count(cmd_n),
    .abort(abort), .pin_out(pin_n), .busy(busy_n), .done(done_n), .done_aborted(done_ab_n)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a train is "elapsed edges since accept"; it ends after N*(H+L) edges.
  bit m_init = 1'b0;
  bit m_on   = 1'b0;
  bit m_done = 1'b0;
  bit m_ab   = 1'b0;
  int m_t, m_h, m_l, m_n;

  always @(posedge clk) begin
    m_done = 1'b0;
    m_ab   = 1'b0;
    if (rst) begin
      m_on   = 1'b0;
      m_init = 1'b1;
    end else if (m_on) begin
      if (abort) begin
        m_on   = 1'b0;
        m_done = 1'b1;
        m_ab   = 1'b1;
      end else begin
        m_t++;
        if (m_t == m_n * (m_h + m_l)) begin
          m_on   = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (cmd_valid) begin
      m_h = (cmd_h == 0) ? 1 : int'(cmd_h);
      m_l = (cmd_l == 0) ? 1 : int'(cmd_l);
      m_n = int'(cmd_n);
      if (m_n == 0) begin
        m_done = 1'b1;
      end else begin
        m_on = 1'b1;
        m_t  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      bit act;
      act = m_on && ((m_t % (m_h + m_l)) < m_h);
      check("model_pin", pin, act);
      check("model_pin_n", pin_n, !act);
      check("model_busy", busy, m_on);
      check("model_busy_n", busy_n, m_on);
      check("model_done", done, m_done);
      check("model_done_n", done_n, m_done);
      check("model_ready", ready, !m_on && !rst);
      check("model_ready_n", ready_n, !m_on && !rst);
      if (m_done) begin
        check("model_done_ab", done_ab, m_ab);
        check("model_done_ab_n", done_ab_n, m_ab);
      end
    end
  end

  // Waits (bounded) for ready, presents a command, returns just after the accept edge.
  task automatic start_cmd(input int h, input int l, input int n);
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 32'd0, 32'd1);
    cmd_h     = CW'(h);
    cmd_l     = CW'(l);
    cmd_n     = RW'(n);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [21:0] basic_pin;
    logic [8:0]  b2b_pin, b2b_done;
    logic [2:0]  deg_pin, deg_done;
    int          rises;
    logic        prev;

    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_h = '0; cmd_l = '0; cmd_n = '0;
    repeat (3) @(negedge clk);
    check("rst_pin", pin, 1'b0);
    check("rst_pin_n", pin_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    #1;

    // Basic train H=3 L=2 N=4: cycles 1..22, MSB is cycle 1.
    basic_pin = 22'b1110011100111001110000;
    rises = 0;
    prev  = 1'b0;
    start_cmd(3, 2, 4);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      check("basic_pin", pin, basic_pin[22-c]);
      check("basic_done", done, (c == 21));
      if (pin && !prev) rises++;
      prev = pin;
    end
    check("basic_rises", rises, 4);
    #1;

    // Degenerate H=0 L=0 N=1 behaves as H=1 L=1.
    deg_pin  = 3'b100;
    deg_done = 3'b001;
    start_cmd(0, 0, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("deg_pin", pin, deg_pin[3-c]);
      check("deg_done", done, deg_done[3-c]);
    end
    #1;

    // N=0: accepted, done next cycle, no pulse.
    start_cmd(4, 4, 0);
    @(negedge clk);
    check("n0_done", done, 1'b1);
    check("n0_ab", done_ab, 1'b0);
    check("n0_busy", busy, 1'b0);
    check("n0_pin_n", pin_n, 1'b1);
    @(negedge clk);
    check("n0_done2", done, 1'b0);
    check("n0_pin", pin, 1'b0);
    #1;

    // Abort in cycle 7 (LOW phase) of H=5 L=5 N=3; abort stays high through an idle accept.
    start_cmd(5, 5, 3);
    repeat (7) @(negedge clk);
    check("ab_pin_c7", pin, 1'b0);
    check("ab_busy_c7", busy, 1'b1);
    #1 abort = 1'b1;
    @(negedge clk);
    check("ab_pin_c8", pin, 1'b0);
    check("ab_done_c8", done, 1'b1);
    check("ab_ab_c8", done_ab, 1'b1);
    check("ab_ready_c8", ready, 1'b1);
    #1;
    cmd_h = CW'(1); cmd_l = CW'(1); cmd_n = RW'(1); cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("ab_new_busy", busy, 1'b1);
    check("ab_new_pin", pin, 1'b1);
    repeat (3) @(negedge clk);
    #1;

    // Back-to-back: valid held; second command accepted in first train's done cycle.
    b2b_pin  = 9'b101001100;
    b2b_done = 9'b000010001;
    cmd_h = CW'(1); cmd_l = CW'(1); cmd_n = RW'(2); cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_h = CW'(2); cmd_l = CW'(1); cmd_n = RW'(1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("b2b_pin", pin, b2b_pin[9-c]);
      check("b2b_done", done, b2b_done[9-c]);
      if (c == 5) check("b2b_ready_c5", ready, 1'b1);
      if (c == 6) begin
        #1 cmd_valid = 1'b0;
      end
    end
    #1;

    // Reset during HIGH phase: active-low instance returns to its idle level 1.
    start_cmd(4, 4, 2);
    repeat (2) @(negedge clk);
    check("rm_pin_n_high", pin_n, 1'b0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rm_pin_n", pin_n, 1'b1);
    check("rm_pin", pin, 1'b0);
    check("rm_busy_n", busy_n, 1'b0);
    check("rm_done_n", done_n, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rm_ready_n", ready_n, 1'b1);
    check("rm_no_done", done_n, 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
